// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the request legality check used at accept time.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    // Illegal size encodings, unsigned stores and misaligned H/W accesses fault.
    function automatic logic req_fault(input logic       write,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
        logic fault;
        case (funct3)
            F3_B:    fault = 1'b0;
            F3_H:    fault = addr_lo[0];
            F3_W:    fault = (addr_lo != 2'b00);
            F3_BU:   fault = write;
            F3_HU:   fault = write | addr_lo[0];
            default: fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends load data from a memory
// word, and merges byte/halfword store data into a read word.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      byte_off,
    input  logic [XLEN-1:0] rdata,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] store_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [4:0]  bit_off;

    // Lane select, extension and store merge.
    always_comb begin
        bit_off    = {byte_off, 3'b000};
        byte_sel   = rdata[bit_off +: 8];
        half_sel   = byte_off[1] ? rdata[31:16] : rdata[15:0];
        load_data  = rdata;
        store_data = rdata;
        case (funct3)
            F3_B:    load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_BU:   load_data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_HU:   load_data = {{(XLEN-16){1'b0}}, half_sel};
            default: load_data = rdata;
        endcase
        case (funct3)
            F3_B: store_data[bit_off +: 8] = wdata[7:0];
            F3_H: begin
                if (byte_off[1]) store_data[31:16] = wdata[15:0];
                else             store_data[15:0]  = wdata[15:0];
            end
            default: store_data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit. Byte and halfword stores are done as
// read-modify-write of the containing word; faults complete without memory
// access.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_data,
    output logic            resp_fault,
    output logic [XLEN-1:0] mem_read_address,
    output logic [XLEN-1:0] mem_write_address,
    output logic [XLEN-1:0] mem_data_write,
    output logic            mem_write_enabled,
    input  logic [XLEN-1:0] mem_data_in
);

    lsu_state_t      state, state_next;
    logic            write_q;
    logic [2:0]      funct3_q;
    logic [1:0]      byte_off_q;
    logic [XLEN-1:0] mem_addr_q;
    logic [XLEN-1:0] mem_wdata_q;
    logic [XLEN-1:0] resp_data_q;
    logic            fault_q;
    logic            accept;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] store_data;

    assign accept = (state == IDLE) && req_valid;

    // mem_wdata_q holds the raw store data until READ replaces it with the merged word.
    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3     (funct3_q),
        .byte_off   (byte_off_q),
        .rdata      (mem_data_in),
        .wdata      (mem_wdata_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_fault(req_write, funct3, addr[1:0])) state_next = RESP;
                    else if (req_write && funct3 == F3_W)      state_next = WRITE;
                    else                                         state_next = READ;
                end
            end
            READ:    state_next = write_q ? WRITE : RESP;
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register, request latch and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            write_q     <= 1'b0;
            funct3_q    <= 3'b000;
            byte_off_q  <= 2'b00;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            resp_data_q <= '0;
            fault_q     <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                write_q     <= req_write;
                funct3_q    <= funct3;
                byte_off_q  <= addr[1:0];
                mem_addr_q  <= {addr[XLEN-1:2], 2'b00};
                mem_wdata_q <= wdata;
                resp_data_q <= '0;
                fault_q     <= req_fault(req_write, funct3, addr[1:0]);
            end
            if (state == READ) begin
                if (write_q) mem_wdata_q <= store_data;
                else         resp_data_q <= load_data;
            end
        end
    end

    assign req_ready         = (state == IDLE);
    assign resp_valid        = (state == RESP);
    assign resp_fault        = fault_q && (state == RESP);
    assign resp_data         = resp_data_q;
    assign mem_read_address  = mem_addr_q;
    assign mem_write_address = mem_addr_q;
    assign mem_data_write    = mem_wdata_q;
    assign mem_write_enabled = (state == WRITE);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word-addressed memory model.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_fault;
    logic [31:0] mem_read_address;
    logic [31:0] mem_write_address;
    logic [31:0] mem_data_write;
    logic        mem_write_enabled;
    logic [31:0] mem_data_in;

    logic [31:0] mem [0:255];

    int n_vec = 0;
    int n_err = 0;

    // Results collected by do_req
    int          r_lat;
    int          r_strobes;
    logic [31:0] r_waddr;
    logic [31:0] r_wdata;
    logic [31:0] r_data;
    logic        r_fault;
    logic        r_ready_seen;

    load_store_unit #(.XLEN(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_write         (req_write),
        .funct3            (funct3),
        .addr              (addr),
        .wdata             (wdata),
        .resp_valid        (resp_valid),
        .resp_data         (resp_data),
        .resp_fault        (resp_fault),
        .mem_read_address  (mem_read_address),
        .mem_write_address (mem_write_address),
        .mem_data_write    (mem_data_write),
        .mem_write_enabled (mem_write_enabled),
        .mem_data_in       (mem_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_data_in = mem[mem_read_address[9:2]];

    always @(posedge clk) begin
        if (mem_write_enabled) mem[mem_write_address[9:2]] <= mem_data_write;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request and follow it to its response (bounded).
    task automatic do_req(input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        funct3    = f3;
        addr      = a;
        wdata     = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        r_lat = 0;
        r_strobes = 0;
        r_waddr = 32'hx;
        r_wdata = 32'hx;
        r_data = 32'hx;
        r_fault = 1'bx;
        r_ready_seen = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (req_ready) r_ready_seen = 1'b1;
            if (mem_write_enabled) begin
                r_strobes++;
                r_waddr = mem_write_address;
                r_wdata = mem_data_write;
            end
            if (resp_valid) begin
                r_lat   = i;
                r_data  = resp_data;
                r_fault = resp_fault;
                break;
            end
        end
    endtask

    initial begin
        req_valid = 1'b0;
        req_write = 1'b0;
        funct3    = 3'b000;
        addr      = 32'h0;
        wdata     = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[32'h100 >> 2] = 32'h8844_22F1;
        mem[32'h200 >> 2] = 32'hCAFE_BABE;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_strobe", {31'b0, mem_write_enabled}, 32'd0);
        check("rst_resp_data", resp_data, 32'h0);
        check("rst_raddr", mem_read_address, 32'h0);
        check("rst_wdata", mem_data_write, 32'h0);
        reset = 1'b0;

        do_req(1'b0, 3'b000, 32'h101, 32'h0);
        check("lb_data", r_data, 32'h0000_0022);
        check("lb_fault", {31'b0, r_fault}, 32'd0);
        check("lb_lat", r_lat, 32'd2);
        check("lb_ready_busy", {31'b0, r_ready_seen}, 32'd0);

        do_req(1'b0, 3'b001, 32'h102, 32'h0);
        check("lh_data", r_data, 32'hFFFF_8844);
        check("lh_lat", r_lat, 32'd2);
        do_req(1'b0, 3'b101, 32'h102, 32'h0);
        check("lhu_data", r_data, 32'h0000_8844);
        do_req(1'b0, 3'b100, 32'h100, 32'h0);
        check("lbu_data", r_data, 32'h0000_00F1);
        do_req(1'b0, 3'b010, 32'h100, 32'h0);
        check("lw_data", r_data, 32'h8844_22F1);

        do_req(1'b1, 3'b000, 32'h103, 32'hDEAD_BE7F);
        check("sb_strobes", r_strobes, 32'd1);
        check("sb_waddr", r_waddr, 32'h100);
        check("sb_wdata", r_wdata, 32'h7F44_22F1);
        check("sb_lat", r_lat, 32'd3);
        check("sb_resp_data", r_data, 32'h0);
        check("sb_fault", {31'b0, r_fault}, 32'd0);
        check("sb_mem", mem[32'h100 >> 2], 32'h7F44_22F1);

        do_req(1'b1, 3'b001, 32'h100, 32'h0000_ABCD);
        check("sh_lo_mem", mem[32'h100 >> 2], 32'h7F44_ABCD);

        do_req(1'b1, 3'b010, 32'h102, 32'h1234_5678);
        check("sw_mis_fault", {31'b0, r_fault}, 32'd1);
        check("sw_mis_lat", r_lat, 32'd1);
        check("sw_mis_strobes", r_strobes, 32'd0);
        check("sw_mis_data", r_data, 32'h0);

        do_req(1'b0, 3'b011, 32'h100, 32'h0);
        check("f3_011_fault", {31'b0, r_fault}, 32'd1);
        check("f3_011_lat", r_lat, 32'd1);
        do_req(1'b0, 3'b001, 32'h101, 32'h0);
        check("lh_mis_fault", {31'b0, r_fault}, 32'd1);
        do_req(1'b1, 3'b100, 32'h100, 32'h0);
        check("sbu_fault", {31'b0, r_fault}, 32'd1);
        check("sbu_strobes", r_strobes, 32'd0);
        check("sbu_mem", mem[32'h100 >> 2], 32'h7F44_ABCD);

        // Reset pulsed while the SH read-modify-write is in WRITE
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        funct3    = 3'b001;
        addr      = 32'h200;
        wdata     = 32'h0000_1111;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("shr_strobe_in_write", {31'b0, mem_write_enabled}, 32'd1);
        check("shr_waddr", mem_write_address, 32'h200);
        reset = 1'b1;
        #1;
        check("shr_strobe_drop", {31'b0, mem_write_enabled}, 32'd0);
        check("shr_waddr_cleared", mem_write_address, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        r_ready_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) r_ready_seen = 1'b1;
        end
        check("shr_no_resp", {31'b0, r_ready_seen}, 32'd0);
        check("shr_ready", {31'b0, req_ready}, 32'd1);
        check("shr_mem", mem[32'h200 >> 2], 32'hCAFE_BABE);

        // Back-to-back SW then LW with req_valid held
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        funct3    = 3'b010;
        addr      = 32'h10;
        wdata     = 32'h1234_5678;
        @(posedge clk);
        #1;
        req_write = 1'b0;
        wdata     = 32'h0;
        @(negedge clk);
        check("b2b_sw_strobe", {31'b0, mem_write_enabled}, 32'd1);
        @(negedge clk);
        check("b2b_sw_resp", {31'b0, resp_valid}, 32'd1);
        check("b2b_ready_in_resp", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        check("b2b_ready_after_resp", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        r_lat = 0;
        r_data = 32'hx;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                r_lat = i;
                r_data = resp_data;
                break;
            end
        end
        check("b2b_lw_lat", r_lat, 32'd2);
        check("b2b_lw_data", r_data, 32'h1234_5678);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, the data/address width (only 32 supported).
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 req_valid  in  1  request present.
REQ-005 req_ready  out  1  unit can accept; high only in IDLE.
REQ-006 req_write  in  1  1=store, 0=load.
REQ-007 funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 addr  in  XLEN  byte address.
REQ-009 wdata  in  XLEN  store data, low bytes used for B/H.
REQ-010 resp_valid  out  1  one-cycle completion pulse.
REQ-011 resp_data  out  XLEN  load result, extended; 0 for stores and faults.
REQ-012 resp_fault  out  1  misaligned or illegal funct3; valid with resp_valid.
REQ-013 mem_read_address  out  XLEN  word-aligned read address to the data-memory interface.
REQ-014 mem_write_address  out  XLEN  word-aligned write address to the data-memory interface.
REQ-015 mem_data_write  out  XLEN  full word to write.
REQ-016 mem_write_enabled  out  1  word write strobe.
REQ-017 mem_data_in  in  XLEN  word read from mem_read_address, valid by the next rising edge.

Function
REQ-018 SHALL use states IDLE, READ, WRITE, RESP; accept when req_valid && req_ready at a rising edge, latching req_write, funct3, addr, wdata.
REQ-019 On accept SHALL go IDLE->RESP with fault if funct3 is 011/110/111, store with funct3 100/101, H with addr[0]=1, or W with addr[1:0]!=0; no memory strobe.
REQ-020 Aligned SW SHALL go IDLE->WRITE; loads, SB, SH SHALL go IDLE->READ.
REQ-021 Memory addresses SHALL be {addr[XLEN-1:2],2'b00}, held stable from accept until the next accept.
REQ-022 READ (1 cycle): load -> RESP with resp_data registered from mem_data_in; SB/SH -> WRITE with merged word registered.
REQ-023 Load extraction: lane addr[1:0] (B) or addr[1] (H); B/H sign-extend, BU/HU zero-extend, W unchanged.
REQ-024 Store merge: replace only addressed byte/halfword of read word with wdata[7:0]/wdata[15:0]; other bytes preserved.
REQ-025 WRITE SHALL assert mem_write_enabled exactly one cycle, then RESP; strobe low in all other states.
REQ-026 RESP SHALL assert resp_valid one cycle, then IDLE; no back-pressure on responses.
REQ-027 Latency from accept edge to resp_valid cycle: fault 1, SW 2, loads 2, SB/SH 3.
REQ-028 req_valid outside IDLE SHALL be ignored (req_ready=0); back-to-back request accepted in IDLE cycle following RESP.

Reset
REQ-029 reset SHALL immediately force IDLE, resp_valid=0, resp_fault=0, resp_data=0, mem_write_enabled=0, all address/data registers 0, independent of clk.
REQ-030 Reset during WRITE SHALL drop the strobe without a rising edge; the write is aborted; in-flight request discarded, no response.

Structure
REQ-031 funct3 encodings and state encodings SHALL live in shared package lsu_pkg.
REQ-032 Lane extraction/extension and merge SHALL be one combinational sub-module lsu_align; FSM and registers in load_store_unit.

Verification
REQ-033 Mem word 0x100=0x8844_22F1; LB addr 0x101 -> resp_data 0x0000_0022, fault 0, resp 2 cycles after accept.
REQ-034 Same word; LH 0x102 -> 0xFFFF_8844; LHU 0x102 -> 0x0000_8844; LBU 0x100 -> 0x0000_00F1.
REQ-035 SB 0x103 wdata 0xDEAD_BE7F -> one strobe, address 0x100, data 0x7F44_22F1, resp 3 cycles after accept.
REQ-036 SW 0x102 -> resp_fault=1 after 1 cycle, mem_write_enabled never high; funct3 011 load -> fault.
REQ-037 SH 0x200 with reset pulsed in WRITE -> strobe falls immediately, no resp_valid, req_ready=1 after release, memory unchanged.
REQ-038 Back-to-back SW 0x10 then LW 0x10 with req_valid held -> second accepted in cycle after first RESP, returns stored value.
